onehot2bin_pipe: RTL and testbench
==================================

# onehot2bin_pipe

Pipelined, parametrised one-hot to binary encoder with valid/ready flow control and input legality checking. It converts a `DATA_WIDTH`-bit one-hot vector to its `$clog2(DATA_WIDTH)`-bit index through a two-stage registered tree. It flags zero-hot and multi-hot inputs and keeps a saturating count of illegal inputs. It sits between grant/select generators (arbiters, match lines) and index-consuming datapaths, replacing the purely combinational encoder where wide vectors break timing.

## Interface
Parameters:
- `DATA_WIDTH`, 16: one-hot input width; legal range ≥ 2; need not be a power of two.
- `GROUP`, 4: stage-1 group width; legal range 2..`DATA_WIDTH`.
- `CNT_WIDTH`, 8: width of the illegal-input counter.

Ports (all synchronous to `clk`; `rst_n` is asynchronous, active-low):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: `din` valid.
- `in_ready`, out, 1: block accepts `din` this cycle.
- `din`, in, `DATA_WIDTH`: one-hot vector.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts result.
- `dout`, out, `$clog2(DATA_WIDTH)`: encoded index (OW below).
- `zero_err`, out, 1: result came from an all-zero `din`.
- `multi_err`, out, 1: result came from a `din` with more than one bit set.
- `err_cnt`, out, `CNT_WIDTH`: saturating count of accepted illegal inputs.
- `cnt_clr`, in, 1: synchronous clear of `err_cnt`.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Stage 1 (S1): split `din` into `ceil(DATA_WIDTH/GROUP)` groups; the top group is zero-padded.
  - Per group, register the local index (OR of set-bit local indices), a group-hit bit and a group-multi bit.
- Stage 2 (S2): combine the group results.
  - `dout = {group index, local index}`, truncated to OW bits.
  - `multi_err` = (more than one group hit) OR (any group-multi).
  - `zero_err` = no group hit.
- Zero-hot input: `dout` = 0, `zero_err` = 1, `multi_err` = 0.
- Multi-hot input, default build: `dout` = bitwise OR of all set-bit indices, `multi_err` = 1.
- `zero_err` and `multi_err` are mutually exclusive and travel with their `dout`.
- `err_cnt` increments by 1 when a result with `zero_err|multi_err` leaves S2. It saturates at `2^CNT_WIDTH-1` and does not wrap.
- `cnt_clr` forces `err_cnt` to 0 next cycle. If `cnt_clr` and an error transfer happen in the same cycle, clear wins: `err_cnt` = 0 and that error is not counted.

## Timing
- Latency: 2 cycles from input transfer to `out_valid` with no stall. Throughput: 1 per cycle.
- Stage enables:
  - `en2 = !v2 || out_ready`
  - `en1 = !v1 || en2`
  - `in_ready = en1`
  - `in_ready` is combinational from `out_ready`; there is no skid buffer.
- Up to 2 results are held under backpressure. Order is preserved.
- `dout`, `zero_err` and `multi_err` stay stable while `out_valid && !out_ready`.
- Reset values: `out_valid` 0, `dout` 0, `zero_err` 0, `multi_err` 0, `err_cnt` 0, stage valids 0. `in_ready` is 1 once `rst_n` is high.
- Reset asserted mid-operation drops all in-flight results immediately (asynchronously). No partial output appears after release.
- Data registers without valid qualification are not required to reset. Their contents must not be visible while `out_valid` = 0, because `dout` and the flags are gated to 0.

## Configuration
- Macro: `ONEHOT2BIN_PRIORITY_EN`.
- Defined: multi-hot inputs encode the lowest set bit index (lowest-index priority in both stages). `multi_err` is still raised and still counted.
- Undefined: OR-of-indices encoding as above; no priority logic is instantiated.
- Latency, handshake and legal one-hot results are identical in both builds.

## Test plan
All scenarios use `DATA_WIDTH`=8 and `GROUP`=4 unless noted.
- `din`=8'b0000_1000, `out_ready`=1: `dout`=3, both error flags 0, `out_valid` exactly 2 cycles after acceptance. Sweep all 8 one-hot values back-to-back: outputs 0..7 in consecutive cycles.
- `din`=0: `dout`=0, `zero_err`=1, `err_cnt` 0→1 on output transfer.
- `din`=8'b0010_0100: default build gives `dout`=7, `multi_err`=1; `ONEHOT2BIN_PRIORITY_EN` build gives `dout`=2, `multi_err`=1.
- Backpressure: drive 4 inputs (1,2,4,8) with `out_ready`=0 for 6 cycles. `in_ready` drops after 2 accepts; `dout`=0 is held stable. On release, outputs are 0,1,2,3 in order and none are lost.
- Counter with `CNT_WIDTH`=2: 5 illegal inputs give `err_cnt`=3. `cnt_clr` coincident with a 6th error gives `err_cnt`=0.
- Async reset: assert `rst_n` low with 2 results in flight. `out_valid` and `err_cnt` drop to 0 immediately, and no stale output appears after release. Repeat with `DATA_WIDTH`=5 and `GROUP`=2: `din`=5'b10000 gives `dout`=4.

Source files
------------

// File: rtl/onehot2bin_pipe.sv
// One-hot to binary encoder, two-stage group tree, zero/multi-hot flags, saturating error count (option: ONEHOT2BIN_PRIORITY_EN).
// Latency 2 cycles, throughput 1/cycle.
// Backpressure: in_ready = !v1 || !v2 || out_ready (combinational, no skid); holds up to 2 results.
module onehot2bin_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int GROUP      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DATA_WIDTH)-1:0] dout,
  output logic                          zero_err,
  output logic                          multi_err,
  output logic [CNT_WIDTH-1:0]          err_cnt,
  input  logic                          cnt_clr
);

  localparam int OW = $clog2(DATA_WIDTH);
  localparam int NG = (DATA_WIDTH + GROUP - 1) / GROUP;
  localparam int LW = $clog2(GROUP);
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int PW = NG * GROUP;

  logic                  en1, en2, v1, v2;
  logic [PW-1:0]         din_pad;
  logic [NG-1:0][LW-1:0] idx_nxt, s1_idx;
  logic [NG-1:0]         hit_nxt, multi_nxt, s1_hit, s1_multi;
  logic [GW-1:0]         gidx;
  logic [LW-1:0]         lidx;
  logic [GW+LW-1:0]      cat;
  logic                  any_hit, many_hit;
  logic [OW-1:0]         dout_r;
  logic                  zero_r, multi_r;
  logic [CNT_WIDTH-1:0]  cnt;

  assign en2      = !v2 || out_ready;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  // Stage 1: per-group local index, hit and multi-hit detection.
  always_comb begin
    din_pad                 = '0;
    din_pad[DATA_WIDTH-1:0] = din;
    idx_nxt                 = '0;
    hit_nxt                 = '0;
    multi_nxt               = '0;
    for (int g = 0; g < NG; g++) begin
      for (int b = 0; b < GROUP; b++) begin
        if (din_pad[g*GROUP + b]) begin
          if (hit_nxt[g]) multi_nxt[g] = 1'b1;
`ifdef ONEHOT2BIN_PRIORITY_EN
          if (!hit_nxt[g]) idx_nxt[g] = LW'(b);
`else
          idx_nxt[g] = idx_nxt[g] | LW'(b);
`endif
          hit_nxt[g] = 1'b1;
        end
      end
    end
  end

  // Stage 2: combine groups into {group index, local index}.
  always_comb begin
    gidx     = '0;
    lidx     = '0;
    any_hit  = 1'b0;
    many_hit = |s1_multi;
    for (int g = 0; g < NG; g++) begin
      if (s1_hit[g]) begin
        if (any_hit) many_hit = 1'b1;
`ifdef ONEHOT2BIN_PRIORITY_EN
        if (!any_hit) begin
          gidx = GW'(g);
          lidx = s1_idx[g];
        end
`else
        gidx = gidx | GW'(g);
        lidx = lidx | s1_idx[g];
`endif
        any_hit = 1'b1;
      end
    end
    cat = {gidx, lidx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      cnt <= '0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      // Clear takes priority over a coincident error transfer.
      if (cnt_clr)
        cnt <= '0;
      else if (v2 && out_ready && (zero_r || multi_r) && (cnt != '1))
        cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // Payload registers need no reset: outputs are gated by v2.
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_idx   <= idx_nxt;
      s1_hit   <= hit_nxt;
      s1_multi <= multi_nxt;
    end
    if (en2 && v1) begin
      dout_r  <= OW'(cat);
      zero_r  <= !any_hit;
      multi_r <= many_hit;
    end
  end

  assign out_valid = v2;
  assign dout      = v2 ? dout_r : '0;
  assign zero_err  = v2 && zero_r;
  assign multi_err = v2 && multi_r;
  assign err_cnt   = cnt;

endmodule

// File: tb/tb_onehot2bin_pipe.sv
// Bench for onehot2bin_pipe: 8/4 main instance, 8/4 with a 2-bit counter, and 5/2 odd-width instance.
module tb_onehot2bin_pipe;

  typedef struct {
    logic [7:0] din;
    logic [2:0] dout;
    logic       zero;
    logic       multi;
  } vec_t;

  logic       clk, rst_n, in_valid, out_ready, cnt_clr;
  logic [7:0] din;
  logic       in_ready_a, out_valid_a, zero_a, multi_a;
  logic [2:0] dout_a;
  logic [7:0] cnt_a;
  logic       in_ready_c, out_valid_c, zero_c, multi_c;
  logic [2:0] dout_c;
  logic [1:0] cnt_c;
  logic       in_valid_b, in_ready_b, out_valid_b, zero_b, multi_b;
  logic [4:0] din_b;
  logic [2:0] dout_b;
  logic [7:0] cnt_b;

  vec_t       tbl[14];
  logic [7:0] bp_vals[4];
  logic [2:0] got_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         exp_cnt;
  int         acc;
  logic       took;

  onehot2bin_pipe #(.DATA_WIDTH(8), .GROUP(4), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .din(din),
    .out_valid(out_valid_a), .out_ready(out_ready), .dout(dout_a), .zero_err(zero_a),
    .multi_err(multi_a), .err_cnt(cnt_a), .cnt_clr(cnt_clr)
  );

  onehot2bin_pipe #(.DATA_WIDTH(8), .GROUP(4), .CNT_WIDTH(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .din(din),
    .out_valid(out_valid_c), .out_ready(out_ready), .dout(dout_c), .zero_err(zero_c),
    .multi_err(multi_c), .err_cnt(cnt_c), .cnt_clr(cnt_clr)
  );

  onehot2bin_pipe #(.DATA_WIDTH(5), .GROUP(2), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .din(din_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .dout(dout_b), .zero_err(zero_b),
    .multi_err(multi_b), .err_cnt(cnt_b), .cnt_clr(cnt_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [7:0] d, input logic [2:0] o,
                         input logic z, input logic m);
    tbl[i].din   = d;
    tbl[i].dout  = o;
    tbl[i].zero  = z;
    tbl[i].multi = m;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) set_vec(i, 8'd1 << i, 3'(i), 1'b0, 1'b0);
    set_vec(8, 8'h00, 3'd0, 1'b1, 1'b0);
`ifdef ONEHOT2BIN_PRIORITY_EN
    set_vec(9,  8'h24, 3'd2, 1'b0, 1'b1);
    set_vec(10, 8'h11, 3'd0, 1'b0, 1'b1);
    set_vec(11, 8'h03, 3'd0, 1'b0, 1'b1);
    set_vec(12, 8'hC0, 3'd6, 1'b0, 1'b1);
    set_vec(13, 8'hFF, 3'd0, 1'b0, 1'b1);
`else
    set_vec(9,  8'h24, 3'd7, 1'b0, 1'b1);
    set_vec(10, 8'h11, 3'd4, 1'b0, 1'b1);
    set_vec(11, 8'h03, 3'd1, 1'b0, 1'b1);
    set_vec(12, 8'hC0, 3'd7, 1'b0, 1'b1);
    set_vec(13, 8'hFF, 3'd7, 1'b0, 1'b1);
`endif
    bp_vals[0] = 8'h01;
    bp_vals[1] = 8'h02;
    bp_vals[2] = 8'h04;
    bp_vals[3] = 8'h08;

    rst_n = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_valid_b = 1'b0; din_b = '0;
    #12;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_zero_err", zero_a, 0);
    chk("rst_multi_err", multi_a, 0);
    chk("rst_err_cnt", cnt_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_in_ready_c", in_ready_c, 1);
    chk("rst_out_valid_c", out_valid_c, 0);
    chk("rst_in_ready_b", in_ready_b, 1);
    chk("rst_out_valid_b", out_valid_b, 0);
    chk("rst_err_cnt_b", cnt_b, 0);
    tick;

    // Isolated vectors: latency, encoding, flags and error count.
    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      din = tbl[i].din;
      #1;
      chk("vec_in_ready", in_ready_a, 1);
      tick;
      in_valid = 1'b0;
      chk("vec_lat1_valid", out_valid_a, 0);
      tick;
      chk("vec_out_valid", out_valid_a, 1);
      chk("vec_dout", dout_a, tbl[i].dout);
      chk("vec_zero_err", zero_a, tbl[i].zero);
      chk("vec_multi_err", multi_a, tbl[i].multi);
      chk("vec_dout_c", dout_c, tbl[i].dout);
      chk("vec_flags_c", {zero_c, multi_c}, {tbl[i].zero, tbl[i].multi});
      tick;
      if (tbl[i].zero || tbl[i].multi) exp_cnt++;
      chk("vec_drained", out_valid_a, 0);
      chk("vec_err_cnt", cnt_a, exp_cnt);
      chk("vec_err_cnt_sat", cnt_c, (exp_cnt > 3) ? 3 : exp_cnt);
    end

    // Back-to-back sweep of all one-hot values.
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      din = (i < 8) ? (8'd1 << i) : 8'h00;
      tick;
      if (i >= 1 && i <= 8) begin
        chk("sweep_valid", out_valid_a, 1);
        chk("sweep_dout", dout_a, i - 1);
      end else begin
        chk("sweep_idle", out_valid_a, 0);
      end
    end
    in_valid = 1'b0;

    // Backpressure: only two results can be held.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 4);
      din = bp_vals[acc & 3];
      #1;
      chk("bp_in_ready", in_ready_a, (c < 2) ? 1 : 0);
      took = in_valid && in_ready_a;
      tick;
      if (took) acc++;
      if (c >= 1) begin
        chk("bp_hold_valid", out_valid_a, 1);
        chk("bp_hold_dout", dout_a, 0);
      end
    end
    chk("bp_accepts", acc, 2);

    out_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 12; c++) begin
      in_valid = (acc < 4);
      din = bp_vals[acc & 3];
      #1;
      took = in_valid && in_ready_a;
      if (out_valid_a) got_q.push_back(dout_a);
      tick;
      if (took) acc++;
    end
    in_valid = 1'b0;
    chk("bp_count", got_q.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("bp_order", (k < got_q.size()) ? 32'(got_q[k]) : 32'hFFFF, k);

    // Saturating counter and clear priority.
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    chk("clr_cnt_a", cnt_a, 0);
    chk("clr_cnt_c", cnt_c, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      din = 8'h00;
      tick;
    end
    in_valid = 1'b0;
    tick; tick; tick;
    chk("sat_cnt_c", cnt_c, 3);
    chk("five_cnt_a", cnt_a, 5);
    in_valid = 1'b1;
    din = 8'h00;
    tick;
    in_valid = 1'b0;
    tick;
    chk("sixth_valid", out_valid_a, 1);
    chk("sixth_zero_err", zero_a, 1);
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    chk("clr_wins_c", cnt_c, 0);
    chk("clr_wins_a", cnt_a, 0);
    tick;
    chk("clr_not_counted_c", cnt_c, 0);
    chk("clr_not_counted_a", cnt_a, 0);

    // Async reset with results in flight.
    in_valid = 1'b1;
    din = 8'h00;
    tick;
    in_valid = 1'b0;
    tick; tick;
    chk("pre_rst_cnt", cnt_a, 1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_valid_b = 1'b1;
    din = 8'h10;
    din_b = 5'b10000;
    tick;
    din = 8'h20;
    din_b = 5'b01000;
    tick;
    in_valid = 1'b0;
    in_valid_b = 1'b0;
    chk("inflight_valid", out_valid_a, 1);
    chk("inflight_valid_b", out_valid_b, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_a, 0);
    chk("async_rst_cnt", cnt_a, 0);
    chk("async_rst_dout", dout_a, 0);
    chk("async_rst_valid_b", out_valid_b, 0);
    tick; tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("no_stale_valid", out_valid_a, 0);
      chk("no_stale_valid_b", out_valid_b, 0);
    end

    // Odd width with GROUP=2.
    in_valid_b = 1'b1;
    din_b = 5'b10000;
    tick;
    din_b = 5'b01000;
    tick;
    in_valid_b = 1'b0;
    chk("w5_valid", out_valid_b, 1);
    chk("w5_dout_4", dout_b, 4);
    chk("w5_flags", {zero_b, multi_b}, 0);
    tick;
    chk("w5_dout_3", dout_b, 3);
    tick;
    chk("w5_drained", out_valid_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
